// File: rtl/bus_timer_pkg.sv
// Shared constants and types for the memory-mapped bus timer.
package bus_timer_pkg;

  // Base byte addresses of the two timer instances behind the bridge.
  localparam logic [31:0] TC1_ADDR = 32'h0000_7F00;
  localparam logic [31:0] TC2_ADDR = 32'h0000_7F10;

  // Word offsets selected by addr[3:2].
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;
  localparam logic [1:0] TC_RSVD   = 2'd3;

  // CTRL bit positions.
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // Counting modes; encodings 2 and 3 behave as one-shot.
  typedef enum logic [1:0] {
    TC_MODE_ONESHOT = 2'd0,
    TC_MODE_RELOAD  = 2'd1,
    TC_MODE_RSVD2   = 2'd2,
    TC_MODE_RSVD3   = 2'd3
  } tc_mode_e;

  // Counter state machine.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  // CTRL register image; field order matches the bit positions above.
  typedef struct packed {
    logic     im;
    tc_mode_e mode;
    logic     en;
  } tc_ctrl_t;

  // Zero-extend CTRL to a bus word.
  function automatic logic [31:0] ctrl_to_word(input tc_ctrl_t c);
    return {28'd0, c};
  endfunction

endpackage

// File: rtl/bus_timer.sv
// Memory-mapped down-counter with CTRL/PRESET/COUNT registers and a level irq.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TC1_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  tc_ctrl_t  ctrl_q,     ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q,  count_d;
  tc_state_e state_q,    state_d;
  logic      int_flag_q, int_flag_d;

  logic       hit;
  logic [1:0] sel;
  logic       wr_ok;
  logic       wr_ctrl;
  logic       wr_preset;
  logic       unused_addr_lsbs;

  assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel       = addr[3:2];
  assign wr_ok     = hit && we && (byteen == 4'b1111);
  assign wr_ctrl   = wr_ok && (sel == TC_CTRL);
  assign wr_preset = wr_ok && (sel == TC_PRESET);

  // Byte offset within a word is irrelevant: only full-word accesses exist.
  assign unused_addr_lsbs = ^addr[1:0];

  assign irq = ctrl_q.im & int_flag_q;

  // Next-state: FSM first, then bus writes so software always wins a collision.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    state_d    = state_q;
    int_flag_d = int_flag_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_q.en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Uses the PRESET value from before this edge, even if it is being written now.
        count_d    = preset_q;
        int_flag_d = 1'b0;
        state_d    = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;               // COUNT freezes where it is
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = 32'd0;
          int_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        state_d = ST_IDLE;
        if (ctrl_q.mode == TC_MODE_RELOAD) begin
          int_flag_d = 1'b0;               // pulse only; EN stays set so it reloads
        end else begin
          ctrl_d.en = 1'b0;                // one-shot and reserved modes stop
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_ctrl) begin
      ctrl_d     = tc_ctrl_t'(wdata[CTRL_IM:CTRL_EN]);
      int_flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d   = wdata;
      int_flag_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      int_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      state_q    <= state_d;
      int_flag_q <= int_flag_d;
    end
  end

  // Combinational read mux; zero when the address misses this timer.
  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      unique case (sel)
        TC_CTRL:   rdata = ctrl_to_word(ctrl_q);
        TC_PRESET: rdata = preset_q;
        TC_COUNT:  rdata = count_q;
        default:   rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: stimulus pushes expectations, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_bus_timer;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] d;
    logic        i;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic chk_valid;
  logic tb_done;
  logic final_done;
  int   n_checks;
  int   n_fail;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;
  localparam logic [31:0] A_TC2    = 32'h0000_7F10;
  localparam logic [31:0] A_TC2P   = 32'h0000_7F14;

  bus_timer #(.BASE_ADDR(32'h0000_7F00)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus cycle: drive just after the rising edge, optionally queue an expectation.
  task automatic drive(input logic [31:0] a, input logic w, input logic [3:0] be,
                       input logic [31:0] wd, input logic r, input logic chk,
                       input logic [31:0] ed, input logic ei, input string n);
    exp_t e;
    @(posedge clk);
    #1;
    addr      = a;
    we        = w;
    byteen    = be;
    wdata     = wd;
    reset     = r;
    chk_valid = chk;
    if (chk) begin
      e.name = n;
      e.d    = ed;
      e.i    = ei;
      sb.push_back(e);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic ei, input string n);
    drive(a, 1'b0, 4'b1111, 32'd0, 1'b0, 1'b1, ed, ei, n);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(a, 1'b1, be, d, 1'b0, 1'b0, 32'd0, 1'b0, "");
  endtask

  // Monitor: compares the DUT against the oldest expectation on every checked cycle.
  always @(negedge clk) begin
    if (chk_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: got rdata=%h irq=%b, required an expectation entry", rdata, irq);
      end else begin
        cur = sb.pop_front();
        if (rdata !== cur.d || irq !== cur.i) begin
          n_fail++;
          $display("FAIL %s: got rdata=%h irq=%b, required rdata=%h irq=%b",
                   cur.name, rdata, irq, cur.d, cur.i);
        end
      end
    end
    if (tb_done && !final_done) begin
      n_checks++;
      if (sb.size() != 0) begin
        n_fail++;
        $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
      end
      final_done = 1'b1;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required end within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m0_cnt [8];
    int m1_cnt [6];
    int md_cnt [5];

    m0_cnt = '{0, 0, 5, 4, 3, 2, 1, 0};
    m1_cnt = '{3, 2, 1, 0, 0, 0};
    md_cnt = '{1, 1, 10, 9, 8};

    n_checks   = 0;
    n_fail     = 0;
    chk_valid  = 1'b0;
    tb_done    = 1'b0;
    final_done = 1'b0;
    reset      = 1'b1;
    addr       = 32'd0;
    we         = 1'b0;
    byteen     = 4'b0000;
    wdata      = 32'd0;

    repeat (3) drive(32'd0, 1'b0, 4'b0000, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, "");

    // Reset state and illegal / missed writes.
    rd(A_CTRL,   32'd0, 1'b0, "rst ctrl");
    rd(A_PRESET, 32'd0, 1'b0, "rst preset");
    rd(A_COUNT,  32'd0, 1'b0, "rst count");
    rd(A_RSVD,   32'd0, 1'b0, "rst rsvd");
    rd(A_TC2,    32'd0, 1'b0, "miss tc2");
    wr(A_PRESET, 32'h0000_1234, 4'b0011);
    rd(A_PRESET, 32'd0, 1'b0, "partial byteen ignored");
    wr(A_TC2P, 32'h0000_0077, 4'b1111);
    rd(A_PRESET, 32'd0, 1'b0, "other base ignored");

    // One-shot: PRESET=5, count 5..1 in CNT, irq on entering INT and sticky.
    wr(A_PRESET, 32'd5, 4'b1111);
    wr(A_CTRL, 32'h9, 4'b1111);
    for (int i = 0; i < 8; i++)
      rd(A_COUNT, 32'(m0_cnt[i]), (i == 7), $sformatf("m0 count[%0d]", i));
    rd(A_CTRL,  32'h8, 1'b1, "m0 ctrl en cleared");
    rd(A_COUNT, 32'd0, 1'b1, "m0 irq sticky");
    wr(A_CTRL, 32'h0, 4'b1111);
    rd(A_CTRL, 32'h0, 1'b0, "m0 irq cleared by ctrl write");

    // Auto-reload: PRESET=3 gives a one-cycle pulse every 6 cycles.
    wr(A_PRESET, 32'd3, 4'b1111);
    wr(A_CTRL, 32'hB, 4'b1111);
    rd(A_COUNT, 32'd0, 1'b0, "m1 idle");
    rd(A_COUNT, 32'd0, 1'b0, "m1 load");
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 6; k++)
        rd(A_COUNT, 32'(m1_cnt[k]), (k == 3), $sformatf("m1 p%0d c%0d", p, k));
    rd(A_CTRL, 32'hB, 1'b0, "m1 en stays set");
    wr(A_CTRL, 32'h0, 4'b1111);            // counter stops holding 1

    // Mid-count disable after 4 CNT cycles, then re-enable reloads.
    wr(A_PRESET, 32'd10, 4'b1111);
    wr(A_CTRL, 32'h9, 4'b1111);
    for (int i = 0; i < 5; i++)
      rd(A_COUNT, 32'(md_cnt[i]), 1'b0, $sformatf("dis count[%0d]", i));
    wr(A_CTRL, 32'h8, 4'b1111);
    for (int i = 0; i < 3; i++)
      rd(A_COUNT, 32'd6, 1'b0, $sformatf("dis frozen[%0d]", i));
    wr(A_CTRL, 32'h9, 4'b1111);
    rd(A_COUNT, 32'd6, 1'b0, "reen idle");
    rd(A_COUNT, 32'd6, 1'b0, "reen load");
    for (int i = 0; i < 10; i++)
      rd(A_COUNT, 32'(10 - i), 1'b0, $sformatf("reen count[%0d]", i));
    // INT cycle: a CTRL write with EN=1 beats the one-shot EN clear.
    wr(A_CTRL, 32'h9, 4'b1111);
    rd(A_COUNT, 32'd0, 1'b0, "prio after int");
    rd(A_CTRL,  32'h9, 1'b0, "prio en kept");
    rd(A_COUNT, 32'd10, 1'b0, "prio restart");
    wr(A_CTRL, 32'h0, 4'b1111);            // stops holding 8

    // PRESET=0: one CNT cycle then INT.
    wr(A_PRESET, 32'd0, 4'b1111);
    wr(A_CTRL, 32'h9, 4'b1111);
    rd(A_COUNT, 32'd8, 1'b0, "p0 idle");
    rd(A_COUNT, 32'd8, 1'b0, "p0 load");
    rd(A_COUNT, 32'd0, 1'b0, "p0 cnt");
    rd(A_COUNT, 32'd0, 1'b1, "p0 int");
    rd(A_COUNT, 32'd0, 1'b1, "p0 after int");
    rd(A_CTRL,  32'h8, 1'b1, "p0 ctrl");
    wr(A_COUNT, 32'h55, 4'b1111);
    rd(A_COUNT, 32'd0, 1'b1, "count write ignored");
    rd(A_RSVD,  32'd0, 1'b1, "rsvd reads zero");

    // PRESET=1 with reset asserted during the INT cycle.
    wr(A_PRESET, 32'd1, 4'b1111);
    wr(A_CTRL, 32'h9, 4'b1111);
    rd(A_COUNT, 32'd0, 1'b0, "p1 idle");
    rd(A_COUNT, 32'd0, 1'b0, "p1 load");
    rd(A_COUNT, 32'd1, 1'b0, "p1 cnt");
    drive(A_COUNT, 1'b0, 4'b1111, 32'd0, 1'b1, 1'b1, 32'd0, 1'b1, "p1 int under reset");
    rd(A_COUNT,  32'd0, 1'b0, "int reset count");
    rd(A_CTRL,   32'd0, 1'b0, "int reset ctrl");
    rd(A_PRESET, 32'd0, 1'b0, "int reset preset");

    // Reset asserted in the middle of CNT.
    wr(A_PRESET, 32'd4, 4'b1111);
    wr(A_CTRL, 32'h9, 4'b1111);
    rd(A_COUNT, 32'd0, 1'b0, "p4 idle");
    rd(A_COUNT, 32'd0, 1'b0, "p4 load");
    rd(A_COUNT, 32'd4, 1'b0, "p4 cnt0");
    rd(A_COUNT, 32'd3, 1'b0, "p4 cnt1");
    drive(A_COUNT, 1'b0, 4'b1111, 32'd0, 1'b1, 1'b1, 32'd2, 1'b0, "p4 cnt under reset");
    rd(A_COUNT,  32'd0, 1'b0, "cnt reset count");
    rd(A_CTRL,   32'd0, 1'b0, "cnt reset ctrl");
    rd(A_PRESET, 32'd0, 1'b0, "cnt reset preset");
    rd(A_COUNT,  32'd0, 1'b0, "cnt reset stays idle");

    @(posedge clk);
    #1;
    chk_valid = 1'b0;
    tb_done   = 1'b1;
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
# bus_timer

Memory-mapped timer/counter that responds to the CPU's M-stage data bus (the responder end of the `m_data_addr`/`m_data_wdata`/`m_data_byteen`/`m_data_rdata` interface). It holds three word registers at a configurable base address (CTRL, PRESET, COUNT). It counts down from PRESET under a small state machine and raises a level interrupt that is wired to one bit of the CPU's `HWInt` input. Two instances sit behind the system bridge, at 0x7F00 (TC1) and 0x7F10 (TC2).

## Interface
- BASE_ADDR, 32'h0000_7F00: byte address of CTRL. PRESET is at BASE+4, COUNT at BASE+8. BASE+0xC is reserved.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address from the CPU's `m_data_addr`.
- we  in  1  write strobe from the bridge, already gated with `!Req`.
- byteen  in  4  byte enables. Only 4'b1111 is a legal write.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational from `addr`.
- irq  out  1  interrupt request, level, to `HWInt`.

## Operation
- Address hit: `addr[31:4] == BASE_ADDR[31:4]`. Word select is `addr[3:2]`.
- Writes happen only when hit && we && byteen == 4'b1111. Any other byteen is ignored; the CPU raises AdES for sh/sb to timer space.
- Register map:
  - 0: CTRL, with [0] EN, [2:1] MODE, [3] IM; [31:4] read as 0.
  - 1: PRESET, all 32 bits.
  - 2: COUNT, read-only. Writes to COUNT are ignored.
  - 3: reserved, reads 0.
- Reads return the addressed register. When not hit, rdata = 0.
- Internal flag `int_flag`. Output: irq = CTRL.IM & int_flag.
- A write to CTRL or PRESET clears int_flag.
- FSM states:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; int_flag <= 0; go to CNT.
  - CNT:
    - if !EN, go to IDLE (COUNT holds);
    - else if COUNT > 1, COUNT <= COUNT-1;
    - else (COUNT ≤ 1), COUNT <= 0, int_flag <= 1, go to INT.
  - INT, MODE 0 (one-shot): EN <= 0, go to IDLE. int_flag stays set until software writes CTRL or PRESET.
  - INT, MODE 1 (auto-reload): int_flag <= 0, go to IDLE. With EN still 1, the counter reloads.
  - MODE 2/3: reserved, behave as MODE 0.
- Simultaneous events:
  - A bus write to CTRL has priority over the FSM's EN clear in INT.
  - A bus write to PRESET in the same cycle as LOAD: LOAD uses the old PRESET.
  - The FSM samples register values before the edge. Writes are visible from the next cycle.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, int_flag=0, irq=0. rdata=0 for every address after reset.
- Read latency is 0 cycles (combinational), so the CPU's M-stage sees data in the same cycle.
- Write latency is 1 cycle: the register holds the new value after the edge.
- The EN write edge is followed by: IDLE (1 cycle), LOAD (1 cycle), CNT.
- CNT lasts max(PRESET,1) cycles, then INT for 1 cycle.
- MODE 0: irq rises on the edge entering INT and stays high until cleared.
- MODE 1:
  - irq is high for exactly the 1 INT cycle.
  - Period = max(PRESET,1) + 3 cycles (CNT + INT + IDLE + LOAD).
- PRESET=0 or 1: exactly one CNT cycle, then INT.
- Clearing EN mid-count: COUNT freezes at its current value. Re-enabling reloads from PRESET.
- Reset mid-count or in INT: all state returns to reset values on that edge, and irq drops the next cycle.

## Structure
- Constants go in `defines.v`:
  - register offsets (`TC_CTRL`, `TC_PRESET`, `TC_COUNT`);
  - CTRL bit positions (EN, MODE, IM);
  - mode encodings (`TC_MODE_ONESHOT`=0, `TC_MODE_RELOAD`=1);
  - state encodings (IDLE/LOAD/CNT/INT, 2 bits).
- `TC1_Addr`/`TC2_Addr` in `defines.v` feed BASE_ADDR at instantiation.
- Single flat module with no sub-module: register file, FSM and read mux are tightly coupled.

## Test plan
- After reset: read 0x7F00, 0x7F04, 0x7F08, 0x7F0C -> all 0, irq=0. A write with byteen=4'b0011 to 0x7F04 -> PRESET stays 0.
- MODE 0: PRESET=5, then CTRL=0b1001 -> COUNT reads 5,4,3,2,1,0. irq rises on the cycle COUNT becomes 0 and stays high. CTRL reads 0b1000. Writing CTRL=0 drops irq the next cycle.
- MODE 1: PRESET=3, CTRL=0b1011 -> irq single-cycle pulses every 6 cycles for at least 3 periods. EN stays 1.
- Mid-count disable: PRESET=10, enable MODE 0, clear EN after 4 CNT cycles -> COUNT frozen at 6, no irq. Re-enable -> COUNT reloads 10.
- Priority and boundaries:
  - A CTRL write of EN=1 in the INT cycle of MODE 0 -> EN remains 1 and the counter restarts.
  - PRESET=0 -> exactly one CNT cycle before INT.
  - A write to 0x7F08 is ignored.
- Reset asserted while in CNT with irq pending: next cycle state=IDLE, COUNT=0, irq=0.
